game_controller: RTL and testbench

Top-level game sequencer that sits directly upstream of the game timer/display stage and consumes its expiry flag.
- Divides the board clock into the 1 s clock and tick.
- Runs the IDLE -> COUNTDOWN -> PLAY -> OVER state machine and drives game_start.
- Keeps the BCD hit score.
- Ends the round when the timer stage raises timer_signal.

---
 rtl/game_controller.sv | 266 ++++++++++++++++++++++++++
 tb/tb_game_controller.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// game_controller: top-level game sequencer for the whack-a-mole board.
// It divides the board clock into a 1 s clock and tick, and runs the
// IDLE -> COUNTDOWN -> PLAY -> OVER state machine. It keeps a saturating
// two-digit BCD score and ends the round on the timer stage's expiry flag.
// Optional build macro: GAME_CONTROLLER_PAUSE_EN adds a pause_btn input.
// Each pause edge in PLAY toggles a pause that freezes the tick divider.
module game_controller #(
  parameter int CLK_FREQ       = 50000000,
  parameter int TICK_HZ        = 1,
  parameter int COUNTDOWN_SECS = 3,
  parameter int OVER_HOLD_SECS = 5
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       hit,
  input  logic       timer_signal,
`ifdef GAME_CONTROLLER_PAUSE_EN
  input  logic       pause_btn,
`endif
  output logic       sec_clk,
  output logic       sec_tick,
  output logic       game_start,
  output logic [1:0] state,
  output logic [3:0] countdown,
  output logic [3:0] score_ones,
  output logic [3:0] score_tens
);

  localparam int DIV   = CLK_FREQ / TICK_HZ;
  localparam int DIV_W = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(DIV / 2);
  localparam logic [3:0]       CD_LOAD   = 4'(COUNTDOWN_SECS);
  localparam logic [3:0]       HOLD_LOAD = 4'(OVER_HOLD_SECS);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_PLAY      = 2'd2,
    ST_OVER      = 2'd3
  } state_e;

  // Saturating BCD increment of {tens, ones}; 99 stays at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] bcd);
    logic [7:0] res;
    if (bcd == 8'h99) begin
      res = bcd;
    end else if (bcd[3:0] == 4'd9) begin
      res = {bcd[7:4] + 4'd1, 4'd0};
    end else begin
      res = {bcd[7:4], bcd[3:0] + 4'd1};
    end
    return res;
  endfunction

  // Synchronizers and edge detect
  logic [1:0] start_sync_q, start_sync_d;
  logic       start_prev_q, start_prev_d;
  logic       start_edge_q, start_edge_d;
  logic [1:0] ts_sync_q, ts_sync_d;
  logic       ts_s;

  // FSM and datapath
  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             sec_tick_q, sec_tick_d;
  logic             sec_clk_q, sec_clk_d;
  logic             game_start_q, game_start_d;
  logic [3:0]       countdown_q, countdown_d;
  logic [3:0]       hold_q, hold_d;
  logic [7:0]       score_q, score_d;
  logic             enter_cd_s;
  logic             run_s;

  // Next values for the button and timer-flag synchronizer chains
  always_comb begin
    start_sync_d = {start_sync_q[0], start_btn};
    start_prev_d = start_sync_q[1];
    start_edge_d = start_sync_q[1] & ~start_prev_q;
    ts_sync_d    = {ts_sync_q[0], timer_signal};
  end

  // Synchronizer and edge-detect flops
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      start_sync_q <= 2'b00;
      start_prev_q <= 1'b0;
      start_edge_q <= 1'b0;
      ts_sync_q    <= 2'b00;
    end else begin
      start_sync_q <= start_sync_d;
      start_prev_q <= start_prev_d;
      start_edge_q <= start_edge_d;
      ts_sync_q    <= ts_sync_d;
    end
  end

  assign ts_s = ts_sync_q[1];

`ifdef GAME_CONTROLLER_PAUSE_EN
  logic [1:0] pause_sync_q, pause_sync_d;
  logic       pause_prev_q, pause_prev_d;
  logic       pause_edge_q, pause_edge_d;
  logic       paused_q, paused_d;

  // Next values for the pause button chain; the flag only toggles in PLAY
  always_comb begin
    pause_sync_d = {pause_sync_q[0], pause_btn};
    pause_prev_d = pause_sync_q[1];
    pause_edge_d = pause_sync_q[1] & ~pause_prev_q;
    if (state_d != ST_PLAY) begin
      paused_d = 1'b0;
    end else if ((state_q == ST_PLAY) && pause_edge_q) begin
      paused_d = ~paused_q;
    end else begin
      paused_d = paused_q;
    end
  end

  // Pause synchronizer, edge detect and paused flag
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      pause_sync_q <= 2'b00;
      pause_prev_q <= 1'b0;
      pause_edge_q <= 1'b0;
      paused_q     <= 1'b0;
    end else begin
      pause_sync_q <= pause_sync_d;
      pause_prev_q <= pause_prev_d;
      pause_edge_q <= pause_edge_d;
      paused_q     <= paused_d;
    end
  end

  assign run_s = ~paused_q;
`else
  assign run_s = 1'b1;
`endif

  // Game state register
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start presses only matter in IDLE and OVER
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_edge_q) begin
          state_d = ST_COUNTDOWN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COUNTDOWN: begin
        if (sec_tick_q && (countdown_q == 4'd1)) begin
          state_d = ST_PLAY;
        end else begin
          state_d = ST_COUNTDOWN;
        end
      end
      ST_PLAY: begin
        if (ts_s) begin
          state_d = ST_OVER;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_OVER: begin
        if (start_edge_q) begin
          state_d = ST_COUNTDOWN;
        end else if (sec_tick_q && (hold_q == 4'd1)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OVER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Divider, countdown, hold timer, score and game_start next values
  always_comb begin
    enter_cd_s = (state_d == ST_COUNTDOWN) && (state_q != ST_COUNTDOWN);

    // Restarting the divider on countdown entry makes the first tick DIV cycles out
    if (enter_cd_s) begin
      div_cnt_d = '0;
    end else if (!run_s) begin
      div_cnt_d = div_cnt_q;
    end else if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
    // Tick and half-period clock are registered views of the next count
    sec_tick_d = run_s && (div_cnt_d == DIV_LAST);
    sec_clk_d  = (div_cnt_d < DIV_HALF);

    if (enter_cd_s) begin
      countdown_d = CD_LOAD;
    end else if ((state_q == ST_COUNTDOWN) && sec_tick_q) begin
      countdown_d = countdown_q - 4'd1;
    end else begin
      countdown_d = countdown_q;
    end

    if ((state_d == ST_OVER) && (state_q != ST_OVER)) begin
      hold_d = HOLD_LOAD;
    end else if ((state_q == ST_OVER) && sec_tick_q && (hold_q != 4'd0)) begin
      hold_d = hold_q - 4'd1;
    end else begin
      hold_d = hold_q;
    end

    // A hit in the same cycle as expiry still counts
    if (enter_cd_s) begin
      score_d = 8'h00;
    end else if ((state_q == ST_PLAY) && hit && run_s) begin
      score_d = bcd_inc(score_q);
    end else begin
      score_d = score_q;
    end

    // Rises one cycle after PLAY entry, drops on the same edge PLAY is left
    game_start_d = (state_q == ST_PLAY) && (state_d == ST_PLAY);
  end

  // Datapath registers
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      div_cnt_q    <= '0;
      sec_tick_q   <= 1'b0;
      sec_clk_q    <= 1'b0;
      countdown_q  <= 4'd0;
      hold_q       <= 4'd0;
      score_q      <= 8'h00;
      game_start_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      sec_tick_q   <= sec_tick_d;
      sec_clk_q    <= sec_clk_d;
      countdown_q  <= countdown_d;
      hold_q       <= hold_d;
      score_q      <= score_d;
      game_start_q <= game_start_d;
    end
  end

  assign sec_clk    = sec_clk_q;
  assign sec_tick   = sec_tick_q;
  assign game_start = game_start_q;
  assign state      = state_q;
  assign countdown  = countdown_q;
  assign score_ones = score_q[3:0];
  assign score_tens = score_q[7:4];

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller with a 10-cycle tick.
module tb_game_controller;

  logic       Clock = 1'b0;
  logic       reset;
  logic       start_btn;
  logic       hit;
  logic       timer_signal;
`ifdef GAME_CONTROLLER_PAUSE_EN
  logic       pause_btn;
`endif
  logic       sec_clk;
  logic       sec_tick;
  logic       game_start;
  logic [1:0] state;
  logic [3:0] countdown;
  logic [3:0] score_ones;
  logic [3:0] score_tens;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         hits;
    logic [3:0] tens;
    logic [3:0] ones;
  } hit_vec_t;

  typedef struct {
    string      nm;
    logic [7:0] v;
  } exp_t;

  hit_vec_t vecs [4];
  exp_t     sb_q [$];

  int w, per, hi, nt, b, early;

  always #5 Clock = ~Clock;

  game_controller #(
    .CLK_FREQ(10), .TICK_HZ(1), .COUNTDOWN_SECS(3), .OVER_HOLD_SECS(5)
  ) dut (
    .Clock(Clock),
    .reset(reset),
    .start_btn(start_btn),
    .hit(hit),
    .timer_signal(timer_signal),
`ifdef GAME_CONTROLLER_PAUSE_EN
    .pause_btn(pause_btn),
`endif
    .sec_clk(sec_clk),
    .sec_tick(sec_tick),
    .game_start(game_start),
    .state(state),
    .countdown(countdown),
    .score_ones(score_ones),
    .score_tens(score_tens)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input string nm, input logic [7:0] v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input logic [7:0] act);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check(e.nm, 32'(act), 32'(e.v));
    end
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin
      hit = 1'b1;
      step(1);
      hit = 1'b0;
      step(1);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int max, input string nm);
    int c;
    c = 0;
    while ((state !== s) && (c < max)) begin
      step(1);
      c++;
    end
    check(nm, 32'(state), 32'(s));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{hits: 12, tens: 4'd1, ones: 4'd2};
    vecs[1] = '{hits: 7,  tens: 4'd1, ones: 4'd9};
    vecs[2] = '{hits: 1,  tens: 4'd2, ones: 4'd0};
    vecs[3] = '{hits: 22, tens: 4'd4, ones: 4'd2};

    reset = 1'b1;
    start_btn = 1'b0;
    hit = 1'b0;
    timer_signal = 1'b0;
`ifdef GAME_CONTROLLER_PAUSE_EN
    pause_btn = 1'b0;
`endif
    step(3);
    check("rst_state", 32'(state), 32'd0);
    check("rst_sec_clk", 32'(sec_clk), 32'd0);
    check("rst_sec_tick", 32'(sec_tick), 32'd0);
    check("rst_game_start", 32'(game_start), 32'd0);
    check("rst_countdown", 32'(countdown), 32'd0);
    check("rst_score", 32'({score_tens, score_ones}), 32'd0);
    reset = 1'b0;

    // Divider: tick every 10 cycles, sec_clk high 5 of them
    w = 0;
    while (!sec_tick && (w < 30)) begin
      step(1);
      w++;
    end
    check("first_tick", 32'(sec_tick), 32'd1);
    per = 0;
    hi = 0;
    do begin
      step(1);
      per++;
      if (sec_clk) hi++;
    end while (!sec_tick && (per < 30));
    check("tick_period", 32'(per), 32'd10);
    check("sec_clk_high", 32'(hi), 32'd5);
    step(1);
    check("tick_width", 32'(sec_tick), 32'd0);

    // Start: countdown entry 4 cycles after the press, then 10-cycle steps
    start_btn = 1'b1;
    step(3);
    check("cd_not_yet", 32'(state), 32'd0);
    step(1);
    check("cd_entry", 32'(state), 32'd1);
    check("cd_load", 32'(countdown), 32'd3);
    start_btn = 1'b0;
    step(9);
    check("cd_still3", 32'(countdown), 32'd3);
    step(1);
    check("cd_2", 32'(countdown), 32'd2);
    step(10);
    check("cd_1", 32'(countdown), 32'd1);
    step(9);
    check("cd_last", 32'(state), 32'd1);
    step(1);
    check("play_entry", 32'(state), 32'd2);
    check("gs_lag", 32'(game_start), 32'd0);
    check("cd_zero", 32'(countdown), 32'd0);
    step(1);
    check("gs_on", 32'(game_start), 32'd1);

    // Table of hit bursts with cumulative BCD score
    for (int i = 0; i < 4; i++) begin
      hits(vecs[i].hits);
      push_exp($sformatf("score_vec%0d", i), {vecs[i].tens, vecs[i].ones});
      pop_check({score_tens, score_ones});
    end

    // Asynchronous reset mid-PLAY at score 42
    reset = 1'b1;
    #1;
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_score", 32'({score_tens, score_ones}), 32'd0);
    check("mid_rst_sec_clk", 32'(sec_clk), 32'd0);
    check("mid_rst_gs", 32'(game_start), 32'd0);
    step(2);
    reset = 1'b0;
    step(1);

    // Second game: score 08, then hit coincident with expiry
    start_btn = 1'b1;
    step(5);
    start_btn = 1'b0;
    wait_state(2'd2, 60, "g2_play");
    hits(8);
    push_exp("score_08", 8'h08);
    pop_check({score_tens, score_ones});

`ifdef GAME_CONTROLLER_PAUSE_EN
    w = 0;
    while (!sec_tick && (w < 30)) begin
      step(1);
      w++;
    end
    check("pause_sync_tick", 32'(sec_tick), 32'd1);
    early = 0;
    pause_btn = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) pause_btn = 1'b0;
      if (k == 12) hit = 1'b1;
      if (k == 13) hit = 1'b0;
      if (k == 31) pause_btn = 1'b1;
      if (k == 35) pause_btn = 1'b0;
      step(1);
      if ((k < 40) && sec_tick) early++;
      if (k == 20) begin
        check("paused_gs", 32'(game_start), 32'd1);
        check("paused_sec_clk", 32'(sec_clk), 32'd1);
      end
      if (k == 40) check("resume_tick", 32'(sec_tick), 32'd1);
    end
    check("frozen_no_tick", 32'(early), 32'd0);
    push_exp("paused_hit_ignored", 8'h08);
    pop_check({score_tens, score_ones});
`endif

    timer_signal = 1'b1;
    step(2);
    hit = 1'b1;
    step(1);
    hit = 1'b0;
    check("same_cycle_state", 32'(state), 32'd3);
    check("same_cycle_gs", 32'(game_start), 32'd0);
    push_exp("same_cycle_score", 8'h09);
    pop_check({score_tens, score_ones});
    timer_signal = 1'b0;

    // Start in OVER: back to COUNTDOWN with score cleared
    step(2);
    start_btn = 1'b1;
    step(4);
    check("over_restart_state", 32'(state), 32'd1);
    push_exp("over_restart_score", 8'h00);
    pop_check({score_tens, score_ones});
    start_btn = 1'b0;

    // Third game: saturation, expiry, hold back to IDLE
    wait_state(2'd2, 60, "g3_play");
    hits(100);
    push_exp("score_sat", 8'h99);
    pop_check({score_tens, score_ones});
    hits(1);
    push_exp("score_sat_again", 8'h99);
    pop_check({score_tens, score_ones});
    timer_signal = 1'b1;
    step(3);
    check("expire_state", 32'(state), 32'd3);
    check("expire_gs", 32'(game_start), 32'd0);
    nt = 0;
    b = 0;
    while ((state == 2'd3) && (b < 80)) begin
      if (sec_tick) nt++;
      step(1);
      b++;
    end
    check("over_ticks", 32'(nt), 32'd5);
    check("over_to_idle", 32'(state), 32'd0);
    push_exp("idle_score_kept", 8'h99);
    pop_check({score_tens, score_ones});
    step(5);
    check("ts_in_idle", 32'(state), 32'd0);
    timer_signal = 1'b0;
    hits(3);
    push_exp("idle_hits_ignored", 8'h99);
    pop_check({score_tens, score_ones});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
